// File: rtl/multi_clk_gate_ctrl.sv
// Multi-channel clock-gating controller: per-channel RUN/HOLD/OFF/WAKE FSM with idle
// hold-off counter, timed wake sequence and a glitch-free latch-based gating cell.
module multi_clk_gate_ctrl #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned WAKE_CYC = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NUM_CH-1:0] ch_en_i,
    input  logic [NUM_CH-1:0] auto_en_i,
    input  logic [NUM_CH-1:0] ch_idle_i,
    input  logic [NUM_CH-1:0] force_on_i,
    input  logic [CNT_W-1:0]  idle_thresh_i,
    output logic [NUM_CH-1:0] gated_clk_o,
    output logic [NUM_CH-1:0] ch_rdy_o,
    output logic              all_off_o
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HOLD = 2'd1,
        ST_OFF  = 2'd2,
        ST_WAKE = 2'd3
    } state_e;

    state_e            state_q [NUM_CH];
    state_e            state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] ch_rdy_q;
    logic [NUM_CH-1:0] ch_rdy_d;
    logic              all_off_q;
    logic              all_off_d;
    logic [NUM_CH-1:0] en_c;
    logic [NUM_CH-1:0] latch_q;

    // State, counter and status registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_RUN;
                cnt_q[i]   <= '0;
            end
            ch_rdy_q  <= '1;
            all_off_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            ch_rdy_q  <= ch_rdy_d;
            all_off_q <= all_off_d;
        end
    end

    // Next-state, counter and status decode per channel
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
        end
        ch_rdy_d  = '0;
        all_off_d = 1'b1;
        en_c      = '0;

        for (int i = 0; i < NUM_CH; i++) begin
            unique case (state_q[i])
                ST_RUN: begin
                    cnt_d[i] = '0;
                    if (force_on_i[i]) begin
                        state_d[i] = ST_RUN;
                    end else if (!ch_en_i[i]) begin
                        state_d[i] = ST_OFF;
                    end else if (auto_en_i[i] && ch_idle_i[i]) begin
                        if (idle_thresh_i == '0) begin
                            state_d[i] = ST_OFF;
                        end else begin
                            state_d[i] = ST_HOLD;
                            cnt_d[i]   = CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (force_on_i[i] || !ch_idle_i[i] || !auto_en_i[i]) begin
                        state_d[i] = ST_RUN;
                        cnt_d[i]   = '0;
                    end else if (!ch_en_i[i]) begin
                        state_d[i] = ST_OFF;
                    end else if (cnt_q[i] >= idle_thresh_i) begin
                        state_d[i] = ST_OFF;
                    end else if (cnt_q[i] != CNT_MAX) begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                ST_OFF: begin
                    if (force_on_i[i] ||
                        (ch_en_i[i] && !(auto_en_i[i] && ch_idle_i[i]))) begin
                        state_d[i] = ST_WAKE;
                        cnt_d[i]   = '0;
                    end
                end
                ST_WAKE: begin
                    // Wake always completes; a dropped enable is handled from RUN.
                    if (cnt_q[i] == WAKE_LAST) begin
                        state_d[i] = ST_RUN;
                    end
                    if (cnt_q[i] != CNT_MAX) begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_RUN;
                    cnt_d[i]   = '0;
                end
            endcase

            en_c[i]     = (state_q[i] != ST_OFF);
            ch_rdy_d[i] = (state_d[i] == ST_RUN) || (state_d[i] == ST_HOLD);
            if (state_d[i] != ST_OFF) begin
                all_off_d = 1'b0;
            end
        end
    end

    // Gating latch: open only while clk is low, forced on during reset
    always_latch begin
        if (!clk_i) begin
            latch_q = en_c | {NUM_CH{rst_i}};
        end
    end

    assign gated_clk_o = {NUM_CH{clk_i}} & latch_q;
    assign ch_rdy_o    = ch_rdy_q;
    assign all_off_o   = all_off_q;

endmodule

// File: tb/tb_multi_clk_gate_ctrl.sv
// Randomized bench for multi_clk_gate_ctrl against an idle-streak / wake-countdown model.
module tb_multi_clk_gate_ctrl;

    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned WAKE_CYC = 2;

    logic              clk;
    logic              rst;
    logic [NUM_CH-1:0] ch_en;
    logic [NUM_CH-1:0] auto_en;
    logic [NUM_CH-1:0] ch_idle;
    logic [NUM_CH-1:0] force_on;
    logic [CNT_W-1:0]  thresh;
    logic [NUM_CH-1:0] gated_clk;
    logic [NUM_CH-1:0] ch_rdy;
    logic              all_off;

    int total = 0;
    int bad   = 0;

    // Model: a channel is either sleeping, waking (edges left), or running with an idle streak
    bit m_off    [NUM_CH];
    int m_wake   [NUM_CH];
    int m_streak [NUM_CH];

    multi_clk_gate_ctrl #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .WAKE_CYC(WAKE_CYC)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .ch_en_i      (ch_en),
        .auto_en_i    (auto_en),
        .ch_idle_i    (ch_idle),
        .force_on_i   (force_on),
        .idle_thresh_i(thresh),
        .gated_clk_o  (gated_clk),
        .ch_rdy_o     (ch_rdy),
        .all_off_o    (all_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NUM_CH-1:0] rbits(input int pct);
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = ($urandom_range(0, 99) < pct);
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] model_en();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = !m_off[i];
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] model_rdy();
        logic [NUM_CH-1:0] v;
        for (int i = 0; i < NUM_CH; i++) v[i] = !m_off[i] && (m_wake[i] == 0);
        return v;
    endfunction

    task automatic model_edge();
        bit idle_q;
        for (int i = 0; i < NUM_CH; i++) begin
            idle_q = auto_en[i] && ch_idle[i];
            if (rst) begin
                m_off[i] = 0; m_wake[i] = 0; m_streak[i] = 0;
            end else if (m_wake[i] > 0) begin
                m_wake[i]--;
            end else if (m_off[i]) begin
                if (force_on[i] || (ch_en[i] && !idle_q)) begin
                    m_off[i] = 0; m_wake[i] = WAKE_CYC; m_streak[i] = 0;
                end
            end else if (force_on[i]) begin
                m_streak[i] = 0;
            end else if (m_streak[i] > 0 && !idle_q) begin
                m_streak[i] = 0;    // leaving hold-off always passes through running
            end else if (!ch_en[i]) begin
                m_off[i] = 1; m_streak[i] = 0;
            end else if (idle_q) begin
                m_streak[i]++;
                if (m_streak[i] > int'(thresh)) begin
                    m_off[i] = 1; m_streak[i] = 0;
                end
            end else begin
                m_streak[i] = 0;
            end
        end
    endtask

    // Inputs already driven for this cycle; check low phase, gated pulse and post-edge status
    task automatic step();
        logic [NUM_CH-1:0] exp_gate;
        logic [NUM_CH-1:0] exp_rdy;
        @(negedge clk);
        #1;
        check("gate_low", 32'(gated_clk), 32'(0));
        exp_gate = model_en() | {NUM_CH{rst}};
        @(posedge clk);
        #1;
        check("gate_high", 32'(gated_clk), 32'(exp_gate));
        #3;
        check("gate_hold", 32'(gated_clk), 32'(exp_gate));
        model_edge();
        exp_rdy = model_rdy();
        check("ch_rdy", 32'(ch_rdy), 32'(exp_rdy));
        check("all_off", 32'(all_off), 32'(exp_rdy == '0 && model_en() == '0));
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) begin
            m_off[i] = 0; m_wake[i] = 0; m_streak[i] = 0;
        end
        rst      = 1'b1;
        ch_en    = '1;
        auto_en  = '0;
        ch_idle  = '0;
        force_on = '0;
        thresh   = 8'd3;

        // Reset for two cycles, clocks must run throughout
        repeat (2) step();
        rst = 1'b0;
        step();
        check("rst_rdy", 32'(ch_rdy), 32'hF);

        // Channel 0 auto-gates after four idle edges with threshold 3
        auto_en = 4'b0001;
        ch_idle = 4'b0001;
        repeat (4) step();
        check("sc2_off", 32'(ch_rdy[0]), 32'(0));
        repeat (2) step();

        // Idle drop wakes channel 0 back up
        ch_idle = '0;
        repeat (3) step();
        check("sc3_rdy", 32'(ch_rdy[0]), 32'(1));

        // Force-on holds a disabled channel, release gates it
        ch_en    = 4'b1011;
        force_on = 4'b0100;
        repeat (3) step();
        force_on = '0;
        repeat (2) step();

        // Zero threshold and everything disabled
        thresh  = '0;
        auto_en = '1;
        ch_idle = '1;
        ch_en   = '1;
        step();
        ch_en = '0;
        step();
        check("sc5_all_off", 32'(all_off), 32'(1));

        // Wake then reset mid-wake
        ch_en   = 4'b1000;
        ch_idle = '0;
        step();
        rst = 1'b1;
        step();
        check("sc6_rdy", 32'(ch_rdy), 32'hF);
        rst = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            rst      = ($urandom_range(0, 99) < 2);
            ch_en    = rbits(85);
            auto_en  = rbits(70);
            ch_idle  = rbits(75);
            force_on = rbits(8);
            if ($urandom_range(0, 15) == 0) thresh = CNT_W'($urandom_range(0, 5));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
